alu_muldiv: RTL

Iterative unsigned multiply/divide unit that sits directly upstream of the 16:1 ALU result mux. It drives the mux data inputs for the MUL and DIV opcode slots. It accepts operands with a start pulse and runs one radix-2 step per clock, 32 steps per operation. It holds the finished result stable on its output until the next accepted start, so the mux can select it at any time.

---
 rtl/alu_muldiv_if.sv | 14 +
 rtl/alu_muldiv.sv | 82 ++++++++
 2 files changed

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: operand/result bundle between the ALU issue logic and the iterative mul/div unit
// Ports: start/op/a/b flow master->slave; busy/done/result/div_by_zero flow slave->master.
interface alu_muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;
    modport master (output start, op, a, b, input busy, done, result, div_by_zero);
    modport slave (input start, op, a, b, output busy, done, result, div_by_zero);
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative unsigned radix-2 multiply/divide feeding the ALU result mux MUL/DIV slots
// Ports: clk, rst (async active-high); bus.start/op/a/b request an operation,
// bus.busy/done/result/div_by_zero report it. op: 00 MULLO, 01 MULHI, 10 DIV, 11 REM.
module alu_muldiv #(parameter int WIDTH = 32) (
    input logic         clk,
    input logic         rst,
    alu_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t             state;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               dz;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    // Multiply consumes b_r LSB-first; divide feeds dividend bits MSB-first from a_r
    // into the remainder, so the accumulator can start cleared for both.
    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_r[0] ? a_r : '0};
        rem_sh = {acc[2*WIDTH-1:WIDTH], a_r[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_r};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            op_r            <= '0;
            a_r             <= '0;
            b_r             <= '0;
            acc             <= '0;
            cnt             <= '0;
            dz              <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.result      <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_r             <= bus.a;
                        b_r             <= bus.b;
                        op_r            <= bus.op;
                        acc             <= '0;
                        cnt             <= '0;
                        dz              <= bus.op[1] && bus.b == '0;
                        bus.div_by_zero <= 1'b0;
                        bus.busy        <= 1'b1;
                        state           <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (op_r[1]) begin
                        // diff[WIDTH] set means the trial subtract went negative: restore
                        acc <= {diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]};
                        a_r <= {a_r[WIDTH-2:0], 1'b0};
                    end else begin
                        acc <= {sum, acc[WIDTH-1:1]};
                        b_r <= b_r >> 1;
                    end
                    if (cnt == CW'(WIDTH - 1))
                        state <= FIN;
                end
                FIN: begin
                    // High half holds MULHI/remainder, low half MULLO/quotient
                    bus.result      <= op_r[0] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
                    bus.div_by_zero <= dz;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
